// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the CPU memory stage
package cpu_pkg;

  localparam int DATA_MEM_SIZE_DEFAULT = 1024;

  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 4'd8;

endpackage

// File: rtl/xfer_check.sv
// rtl/xfer_check.sv - legality, alignment and bounds check for a memory transfer
module xfer_check
  import cpu_pkg::*;
#(
  parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEFAULT
) (
  input  logic [63:0] address,
  input  logic [3:0]  xfer_size,
  output logic        valid
);

  logic size_ok;
  logic aligned;
  logic in_range;

  always_comb begin
    size_ok  = (xfer_size == XFER_B) || (xfer_size == XFER_H) ||
               (xfer_size == XFER_W) || (xfer_size == XFER_D);
    // Legal sizes are powers of two, so alignment only involves the low three address bits.
    aligned  = (({1'b0, address[2:0]} & (xfer_size - 4'd1)) == 4'd0);
    // Subtracting from the memory size avoids any wrap of address + size near 2^64.
    in_range = address <= (64'(DATA_MEM_SIZE) - {60'd0, xfer_size});
    valid    = size_ok && aligned && in_range;
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable big-endian data memory, combinational read, synchronous write
module data_memory
  import cpu_pkg::*;
#(
  parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic [63:0] read_data
);

  localparam int AW = $clog2(DATA_MEM_SIZE);

  logic valid;

  logic [7:0]    mem_q [DATA_MEM_SIZE];
  logic [7:0]    mem_d [DATA_MEM_SIZE];

  logic [7:0]    lane_en;
  logic [AW-1:0] lane_addr  [8];
  logic [6:0]    lane_shamt [8];
  logic [7:0]    lane_wdata [8];
  logic [63:0]   lane_rword [8];

  xfer_check #(
    .DATA_MEM_SIZE(DATA_MEM_SIZE)
  ) u_xfer_check (
    .address  (address),
    .xfer_size(xfer_size),
    .valid    (valid)
  );

  // Lane i carries byte address+i, which sits 8*(size-1-i) bits up in the word (big-endian).
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane_en[i]    = (4'(i) < xfer_size);
    assign lane_addr[i]  = address[AW-1:0] + AW'(i);
    assign lane_shamt[i] = {xfer_size - 4'(i + 1), 3'b000};
    assign lane_wdata[i] = 8'(write_data >> lane_shamt[i]);
    assign lane_rword[i] = lane_en[i] ? (64'(mem_q[lane_addr[i]]) << lane_shamt[i]) : 64'd0;
  end

  always_comb begin
    read_data = 64'd0;
    if (read_enable && valid) begin
      for (int i = 0; i < 8; i++) begin
        read_data = read_data | lane_rword[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < DATA_MEM_SIZE; j++) begin
      mem_d[j] = mem_q[j];
    end
    if (write_enable && valid) begin
      for (int i = 0; i < 8; i++) begin
        if (lane_en[i]) begin
          mem_d[lane_addr[i]] = lane_wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DATA_MEM_SIZE; j++) begin
      if (reset) begin
        mem_q[j] <= 8'd0;
      end else begin
        mem_q[j] <= mem_d[j];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory against a byte-array reference model
module tb_data_memory;

  localparam int MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] address;
  logic        write_enable;
  logic        read_enable;
  logic [63:0] write_data;
  logic [3:0]  xfer_size;
  logic [63:0] read_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_mem [MEM_SIZE];

  data_memory #(
    .DATA_MEM_SIZE(MEM_SIZE)
  ) datamem (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .write_data  (write_data),
    .xfer_size   (xfer_size),
    .read_data   (read_data)
  );

  always #5 clk = ~clk;

  function automatic bit ref_valid(input logic [63:0] a, input int s);
    if (!(s inside {1, 2, 4, 8})) return 1'b0;
    if ((a % 64'(s)) != 64'd0) return 1'b0;
    return ({1'b0, a} + 65'(s)) <= 65'(MEM_SIZE);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a, input int s);
    logic [63:0] v;
    v = 64'd0;
    if (!ref_valid(a, s)) return 64'd0;
    for (int i = 0; i < s; i++) v = (v << 8) | 64'(ref_mem[int'(a) + i]);
    return v;
  endfunction

  task automatic ref_write(input logic [63:0] a, input int s, input logic [63:0] d);
    if (ref_valid(a, s)) begin
      for (int i = 0; i < s; i++) ref_mem[int'(a) + i] = d[8*(s-1-i) +: 8];
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [63:0] a, input logic [3:0] s, input logic re);
    @(negedge clk);
    address = a; xfer_size = s; read_enable = re; write_enable = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
    @(negedge clk);
    address = a; xfer_size = s; write_data = d; write_enable = 1'b1; read_enable = 1'b0;
    @(posedge clk);
    ref_write(a, int'(s), d);
    #1 write_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  initial begin
    int          sz;
    int          r;
    logic [63:0] a;
    logic [63:0] d;
    int          sizes [10] = '{1, 2, 4, 8, 1, 2, 4, 8, 3, 0};

    reset = 1'b1; address = '0; write_enable = 1'b0; read_enable = 1'b0;
    write_data = '0; xfer_size = 4'd8;
    repeat (2) @(posedge clk);
    foreach (ref_mem[k]) ref_mem[k] = 8'd0;
    #1 reset = 1'b0;

    rd(64'd0, 4'd8, 1'b1);    check("reset_rd0", read_data, 64'd0);
    rd(64'd1016, 4'd8, 1'b1); check("reset_rd1016", read_data, 64'd0);

    wr(64'd128, 4'd8, 64'h0123_4567_89AB_CDEF);
    rd(64'd128, 4'd8, 1'b1);  check("rd8_128", read_data, 64'h0123456789ABCDEF);
    rd(64'd128, 4'd1, 1'b1);  check("rd1_128", read_data, 64'h01);
    rd(64'd135, 4'd1, 1'b1);  check("rd1_135", read_data, 64'hEF);
    rd(64'd132, 4'd4, 1'b1);  check("rd4_132", read_data, 64'h89ABCDEF);

    wr(64'd129, 4'd1, 64'hFFFF_FFFF_FFFF_FF45);
    rd(64'd128, 4'd8, 1'b1);  check("byte_merge_rd8", read_data, 64'h0145456789ABCDEF);
    rd(64'd128, 4'd2, 1'b1);  check("byte_merge_rd2", read_data, 64'h0145);

    wr(64'd132, 4'd8, 64'd69);
    wr(64'd1024, 4'd8, 64'd69);
    wr(64'd128, 4'd3, 64'd69);
    wr(64'hFFFF_FFFF_FFFF_FFF8, 4'd8, 64'd69);
    rd(64'd132, 4'd8, 1'b1);  check("rd_misaligned", read_data, 64'd0);
    rd(64'd1024, 4'd8, 1'b1); check("rd_out_of_range", read_data, 64'd0);
    rd(64'd128, 4'd3, 1'b1);  check("rd_size3", read_data, 64'd0);
    rd(64'hFFFF_FFFF_FFFF_FFF8, 4'd8, 1'b1); check("rd_wrap_addr", read_data, 64'd0);
    rd(64'd1016, 4'd8, 1'b1); check("rd_1016_untouched", read_data, 64'd0);
    rd(64'd128, 4'd8, 1'b1);  check("invalid_writes_noop", read_data, 64'h0145456789ABCDEF);

    rd(64'd128, 4'd8, 1'b0);  check("re_low_zero", read_data, 64'd0);
    rd(64'd128, 4'd8, 1'b1);  check("re_low_retained", read_data, 64'h0145456789ABCDEF);

    wr(64'd1016, 4'd8, 64'hDEAD_BEEF_CAFE_F00D);
    rd(64'd1022, 4'd2, 1'b1); check("top_edge_rd2", read_data, 64'hF00D);

    @(negedge clk);
    address = 64'd256; xfer_size = 4'd4; write_data = 64'h1122_3344;
    write_enable = 1'b1; read_enable = 1'b1;
    #1 check("same_cycle_old", read_data, 64'd0);
    @(posedge clk);
    ref_write(64'd256, 4, 64'h1122_3344);
    #1 check("same_cycle_new", read_data, 64'h11223344);
    write_enable = 1'b0;

    @(negedge clk);
    reset = 1'b1; write_enable = 1'b1; address = 64'd512; xfer_size = 4'd8;
    write_data = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk);
    foreach (ref_mem[k]) ref_mem[k] = 8'd0;
    #1 reset = 1'b0; write_enable = 1'b0;
    rd(64'd512, 4'd8, 1'b1);  check("reset_beats_write", read_data, 64'd0);
    rd(64'd128, 4'd8, 1'b1);  check("reset_clears_128", read_data, 64'd0);
    rd(64'd1016, 4'd8, 1'b1); check("reset_clears_1016", read_data, 64'd0);

    for (int n = 0; n < 400; n++) begin
      sz = sizes[$urandom_range(0, 9)];
      r  = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, MEM_SIZE - 1)) & ~64'((sz > 0) ? sz - 1 : 0);
      else if (r == 7) a = 64'($urandom_range(0, MEM_SIZE - 1));
      else if (r == 8) a = 64'(MEM_SIZE) + 64'($urandom_range(0, 64));
      else             a = {32'hFFFF_FFFF, 32'($urandom)};
      d = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        wr(a, 4'(sz), d);
      end else begin
        r = $urandom_range(0, 7);
        rd(a, 4'(sz), r != 0);
        check("rand_read", read_data, (r != 0) ? ref_read(a, sz) : 64'd0);
      end
    end

    for (int k = 0; k < MEM_SIZE; k += 8) begin
      rd(64'(k), 4'd8, 1'b1);
      check("sweep_rd8", read_data, ref_read(64'(k), 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
